// File: rtl/aa.sv
// rtl/aa.sv - register-file execution core (32 x 16-bit GPR, SGPR, IR)
//
// Two-stage core: an instruction is captured into IR on one edge and executed
// on the next. Because the execute and capture stages overlap, one instruction
// can be issued per clock.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        synchronous reset, active low
//   instr_valid  capture instr into IR on this edge
//   instr        32-bit instruction word
//   ld_en        GPR preload strobe
//   ld_addr      GPR preload index
//   ld_data      GPR preload value
//   dbg_addr     GPR read index
//   dbg_data     combinational GPR[dbg_addr]
//   sgpr         current SGPR value
//   busy         high while a captured instruction awaits execution
module aa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [4:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic [15:0] sgpr,
  output logic        busy
);

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;

  // State keeps the plain names IR/GPR/SGPR so benches can reach them
  // hierarchically.
  logic [31:0] IR;
  logic [15:0] GPR [0:31];
  logic [15:0] SGPR;
  logic        r_exe;

  // Instruction field decode
  logic [4:0]  w_oper_type;
  logic [4:0]  w_rdst;
  logic [4:0]  w_rsrc1;
  logic        w_imm_mode;
  logic [4:0]  w_rsrc2;
  logic [15:0] w_isrc;

  assign w_oper_type = IR[31:27];
  assign w_rdst      = IR[26:22];
  assign w_rsrc1     = IR[21:17];
  assign w_imm_mode  = IR[16];
  assign w_rsrc2     = IR[15:11];
  assign w_isrc      = IR[15:0];

  // Operands come from the register file as it stands before this edge, so
  // rdst may alias either source.
  logic [15:0] w_op_a;
  logic [15:0] w_op_b;
  logic [31:0] w_prod;

  assign w_op_a = GPR[w_rsrc1];
  assign w_op_b = w_imm_mode ? w_isrc : GPR[w_rsrc2];
  assign w_prod = w_op_a * w_op_b;

  logic        w_gpr_we;
  logic [15:0] w_gpr_wdata;
  logic        w_sgpr_we;

  always_comb begin
    w_gpr_we    = 1'b0;
    w_gpr_wdata = 16'd0;
    w_sgpr_we   = 1'b0;
    if (r_exe) begin
      case (w_oper_type)
        OP_MOVSGPR: begin
          w_gpr_we    = 1'b1;
          w_gpr_wdata = SGPR;
        end
        OP_MOV: begin
          w_gpr_we    = 1'b1;
          // MOV's register form copies rsrc1, not rsrc2
          w_gpr_wdata = w_imm_mode ? w_isrc : w_op_a;
        end
        OP_ADD: begin
          w_gpr_we    = 1'b1;
          w_gpr_wdata = w_op_a + w_op_b;
        end
        OP_SUB: begin
          w_gpr_we    = 1'b1;
          w_gpr_wdata = w_op_a - w_op_b;
        end
        OP_MUL: begin
          w_gpr_we    = 1'b1;
          w_gpr_wdata = w_prod[15:0];
          w_sgpr_we   = 1'b1;
        end
        default: begin
          // opcodes 5..31 leave all state untouched
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      IR    <= 32'd0;
      SGPR  <= 16'd0;
      r_exe <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        GPR[i] <= 16'd0;
      end
    end else begin
      if (instr_valid) begin
        IR <= instr;
      end
      r_exe <= instr_valid;
      if (ld_en) begin
        GPR[ld_addr] <= ld_data;
      end
      // Placed after the preload so an execute write to the same index wins.
      if (w_gpr_we) begin
        GPR[w_rdst] <= w_gpr_wdata;
      end
      if (w_sgpr_we) begin
        SGPR <= w_prod[31:16];
      end
    end
  end

  assign dbg_data = GPR[dbg_addr];
  assign sgpr     = SGPR;
  assign busy     = r_exe;

endmodule

// File: tb/tb_aa.sv
// tb/tb_aa.sv - directed self-checking bench for aa
module tb_aa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] sgpr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  aa dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .sgpr        (sgpr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_imm(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] enc_reg(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  // Advance one rising edge; return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gpr(input string tag, input logic [4:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Capture edge then execute edge, with a busy check in between.
  task automatic exec1(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    tick();
    instr_valid = 1'b0;
    chk("busy_pending", {31'd0, busy}, 32'd1);
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    ld_en       = 1'b0;
    ld_addr     = 5'd0;
    ld_data     = 16'd0;
    dbg_addr    = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sgpr", {16'd0, sgpr}, 32'd0);
    chk("rst_ir", dut.IR, 32'd0);
    chk_gpr("rst_gpr9", 5'd9, 16'd0);

    for (int i = 0; i < 32; i++) preload(5'(i), 16'd2);
    chk_gpr("preload_r31", 5'd31, 16'd2);

    exec1(enc_imm(5'd2, 5'd0, 5'd2, 16'd4));
    chk_gpr("add_imm", 5'd0, 16'd6);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    exec1(enc_reg(5'd2, 5'd0, 5'd4, 5'd5));
    chk_gpr("add_reg", 5'd0, 16'd4);
    exec1(enc_imm(5'd1, 5'd4, 5'd0, 16'd55));
    chk_gpr("mov_imm", 5'd4, 16'd55);
    exec1(enc_reg(5'd1, 5'd4, 5'd7, 5'd0));
    chk_gpr("mov_reg", 5'd4, 16'd2);

    exec1(enc_imm(5'd3, 5'd6, 5'd2, 16'd4));
    chk_gpr("sub_wrap", 5'd6, 16'hFFFE);
    chk("sub_sgpr", {16'd0, sgpr}, 32'd0);
    preload(5'd8, 16'hFFFF);
    exec1(enc_imm(5'd2, 5'd9, 5'd8, 16'd2));
    chk_gpr("add_wrap", 5'd9, 16'h0001);
    chk("add_sgpr", {16'd0, sgpr}, 32'd0);

    preload(5'd1, 16'h1234);
    preload(5'd2, 16'h0100);
    exec1(enc_reg(5'd4, 5'd3, 5'd1, 5'd2));
    chk_gpr("mul_lo", 5'd3, 16'h3400);
    chk("mul_hi", {16'd0, sgpr}, 32'h0012);
    exec1(enc_imm(5'd0, 5'd5, 5'd0, 16'hFFFF));
    chk_gpr("movsgpr", 5'd5, 16'h0012);

    // Back-to-back with dependency on the previous destination
    preload(5'd2, 16'd2);
    instr_valid = 1'b1;
    instr = enc_imm(5'd2, 5'd0, 5'd2, 16'd4);
    tick();
    instr = enc_reg(5'd2, 5'd1, 5'd0, 5'd0);
    tick();
    chk_gpr("b2b_r0", 5'd0, 16'd6);
    chk("b2b_busy1", {31'd0, busy}, 32'd1);
    instr = enc_imm(5'd1, 5'd2, 5'd0, 16'd9);
    tick();
    instr_valid = 1'b0;
    chk_gpr("b2b_r1", 5'd1, 16'd12);
    chk_gpr("b2b_r2_old", 5'd2, 16'd2);
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk_gpr("b2b_r2", 5'd2, 16'd9);
    chk("b2b_busy3", {31'd0, busy}, 32'd0);

    // Unused opcode
    preload(5'd10, 16'h7777);
    exec1(enc_imm(5'd7, 5'd10, 5'd1, 16'h1111));
    chk_gpr("nop_r10", 5'd10, 16'h7777);
    chk_gpr("nop_r0", 5'd0, 16'd6);
    chk("nop_sgpr", {16'd0, sgpr}, 32'h0012);

    // Preload colliding with an execute write, and one on a different index
    instr_valid = 1'b1;
    instr = enc_imm(5'd1, 5'd11, 5'd0, 16'hAAAA);
    tick();
    instr_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 5'd11; ld_data = 16'h5555;
    tick();
    ld_en = 1'b0;
    chk_gpr("collide", 5'd11, 16'hAAAA);
    instr_valid = 1'b1;
    instr = enc_imm(5'd1, 5'd13, 5'd0, 16'h0BAD);
    tick();
    instr_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 5'd14; ld_data = 16'h4444;
    tick();
    ld_en = 1'b0;
    chk_gpr("dual_exe", 5'd13, 16'h0BAD);
    chk_gpr("dual_ld", 5'd14, 16'h4444);

    // Reset on the execute edge of a pending MUL
    preload(5'd1, 16'hFFFF);
    preload(5'd2, 16'hFFFF);
    instr_valid = 1'b1;
    instr = enc_reg(5'd4, 5'd3, 5'd1, 5'd2);
    tick();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_sgpr", {16'd0, sgpr}, 32'd0);
    chk("rst2_ir", dut.IR, 32'd0);
    for (int i = 0; i < 32; i++) chk_gpr($sformatf("rst2_gpr%0d", i), 5'(i), 16'd0);
    tick();
    chk_gpr("rst2_no_late_wr", 5'd3, 16'd0);
    chk("rst2_sgpr_late", {16'd0, sgpr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
